riscv_lsu: RTL and testbench



---
 rtl/riscv_lsu_if.sv | 31 +++
 rtl/riscv_lsu.sv | 163 ++++++++++++++++
 tb/tb_riscv_lsu.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_lsu_if.sv
// Core-side request/response and memory-side strobe bundle for the load/store unit.
// The slave modport is the LSU view; master is the core/memory environment view.
interface riscv_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] addr_riscv;
  logic [31:0] wdata_riscv;
  logic        wr_en_riscv;
  logic        cs_en_riscv;
  logic [31:0] rdata_mem;

  modport slave (
    input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, rdata_mem,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output addr_riscv, wdata_riscv, wr_en_riscv, cs_en_riscv
  );

  modport master (
    output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, rdata_mem,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  addr_riscv, wdata_riscv, wr_en_riscv, cs_en_riscv
  );
endinterface

// File: rtl/riscv_lsu.sv
// Load/store unit in front of a word-addressed memory with one-cycle registered read.
// Sub-word stores are read-modify-write; misaligned accesses complete with an error.
module riscv_lsu (
  input  logic        clk,
  input  logic        rst,
  riscv_lsu_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StWb, StDone} state_e;

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        misalign;
  logic        word_store;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic        cs_en, wr_en;
  logic [31:0] mem_wdata;

  assign bus.req_ready   = (state_q == StIdle) & ~rst;
  assign accept          = bus.req_valid & bus.req_ready;
  assign bus.resp_valid  = (state_q == StDone);
  assign bus.resp_rdata  = rdata_q;
  assign bus.resp_err    = err_q;
  assign bus.addr_riscv  = {addr_q[31:2], 2'b00};
  assign bus.cs_en_riscv = cs_en;
  assign bus.wr_en_riscv = wr_en;
  assign bus.wdata_riscv = mem_wdata;

  assign misalign = (bus.req_size == 2'b11) |
                    ((bus.req_size == 2'b01) & bus.req_addr[0]) |
                    ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00));

  assign word_store = wr_q & (size_q == 2'b10);

  // Lane selection and extension of the word returned in WAIT
  always_comb begin
    byte_lane = bus.rdata_mem[{addr_q[1:0], 3'b000} +: 8];
    half_lane = bus.rdata_mem[{addr_q[1], 4'b0000} +: 16];
    load_data = bus.rdata_mem;
    case (size_q)
      2'b00:   load_data = uns_q ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      2'b01:   load_data = uns_q ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: load_data = bus.rdata_mem;
    endcase
  end

  // Replace the target lane of the fetched word with the right-aligned store data
  always_comb begin
    merged = bus.rdata_mem;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = bus.rdata_mem;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    merge_d   = merge_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cs_en     = 1'b0;
    wr_en     = 1'b0;
    mem_wdata = 32'h0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          wr_d    = bus.req_wr;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (misalign) begin
            err_d   = 1'b1;
            rdata_d = 32'h0;
            state_d = StDone;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        cs_en = 1'b1;
        if (word_store) begin
          wr_en     = 1'b1;
          mem_wdata = wdata_q;
          err_d     = 1'b0;
          rdata_d   = 32'h0;
          state_d   = StDone;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (wr_q) begin
          merge_d = merged;
          state_d = StWb;
        end else begin
          rdata_d = load_data;
          err_d   = 1'b0;
          state_d = StDone;
        end
      end
      StWb: begin
        cs_en     = 1'b1;
        wr_en     = 1'b1;
        mem_wdata = merge_q;
        err_d     = 1'b0;
        rdata_d   = 32'h0;
        state_d   = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu with a behavioural one-cycle-read word memory.
module tb_riscv_lsu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_lsu_if bus ();

  riscv_lsu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:63];

  always @(posedge clk) begin
    if (bus.cs_en_riscv) begin
      if (bus.wr_en_riscv) mem[bus.addr_riscv[7:2]] <= bus.wdata_riscv;
      else                 bus.rdata_mem <= mem[bus.addr_riscv[7:2]];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_wr       = wr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
  endtask

  // Called #1 after a rising edge with the unit idle; returns the same way.
  task automatic access(input string tag, input logic wr, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_rd, input int exp_wr, input logic [31:0] exp_wdata);
    int          lat, rd, wrc;
    logic [31:0] wd, got_rdata;
    logic        got_err, ready_at_resp;
    lat = 0; rd = 0; wrc = 0; wd = 32'h0; got_rdata = 32'h0; got_err = 1'b0;
    ready_at_resp = 1'b0;
    set_req(wr, size, uns, addr, wdata);
    bus.req_valid = 1'b1;
    @(negedge clk);
    check_eq({tag, "/ready"}, {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (bus.cs_en_riscv && !bus.wr_en_riscv && rd == 0) rd = c;
      if (bus.cs_en_riscv && bus.wr_en_riscv) begin
        wrc = c;
        wd  = bus.wdata_riscv;
      end
      if (bus.resp_valid) begin
        lat           = c;
        got_rdata     = bus.resp_rdata;
        got_err       = bus.resp_err;
        ready_at_resp = bus.req_ready;
      end
    end
    check_eq({tag, "/latency"}, lat, exp_lat);
    check_eq({tag, "/rdata"}, got_rdata, exp_rdata);
    check_eq({tag, "/err"}, {31'h0, got_err}, {31'h0, exp_err});
    check_eq({tag, "/rd_cycle"}, rd, exp_rd);
    check_eq({tag, "/wr_cycle"}, wrc, exp_wr);
    check_eq({tag, "/wdata"}, wd, exp_wdata);
    check_eq({tag, "/ready_at_resp"}, {31'h0, ready_at_resp}, 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "/resp_valid"}, {31'h0, bus.resp_valid}, 32'h0);
    check_eq({tag, "/resp_rdata"}, bus.resp_rdata, 32'h0);
    check_eq({tag, "/resp_err"}, {31'h0, bus.resp_err}, 32'h0);
    check_eq({tag, "/cs_en"}, {31'h0, bus.cs_en_riscv}, 32'h0);
    check_eq({tag, "/wr_en"}, {31'h0, bus.wr_en_riscv}, 32'h0);
    check_eq({tag, "/addr"}, bus.addr_riscv, 32'h0);
    check_eq({tag, "/wdata"}, bus.wdata_riscv, 32'h0);
    check_eq({tag, "/ready"}, {31'h0, bus.req_ready}, 32'h1);
  endtask

  int          a_resp, b_acc, b_resp, overlap, activity;
  logic [31:0] a_data, b_data;
  logic        go;

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b1;
    set_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h0BAD0BAD);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst/ready", {31'h0, bus.req_ready}, 32'h0);
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;

    // Word store then load
    access("sw100", 1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 2, 32'h0, 0, 0, 1, 32'hDEADBEEF);
    access("lw100", 0, 2'b10, 0, 32'h100, 32'h0, 3, 32'hDEADBEEF, 0, 1, 0, 32'h0);

    // Byte store read-modify-write
    access("sw100b", 1, 2'b10, 0, 32'h100, 32'h11223344, 2, 32'h0, 0, 0, 1, 32'h11223344);
    access("sb102", 1, 2'b00, 0, 32'h102, 32'h000000AB, 4, 32'h0, 0, 1, 3, 32'h11AB3344);
    access("lw100c", 0, 2'b10, 0, 32'h100, 32'h0, 3, 32'h11AB3344, 0, 1, 0, 32'h0);

    // Sign / zero extension
    access("sw104", 1, 2'b10, 0, 32'h104, 32'h80F07F01, 2, 32'h0, 0, 0, 1, 32'h80F07F01);
    access("lb107", 0, 2'b00, 0, 32'h107, 32'h0, 3, 32'hFFFFFF80, 0, 1, 0, 32'h0);
    access("lbu107", 0, 2'b00, 1, 32'h107, 32'h0, 3, 32'h00000080, 0, 1, 0, 32'h0);
    access("lh106", 0, 2'b01, 0, 32'h106, 32'h0, 3, 32'hFFFF80F0, 0, 1, 0, 32'h0);
    access("lhu104", 0, 2'b01, 1, 32'h104, 32'h0, 3, 32'h00007F01, 0, 1, 0, 32'h0);
    access("lb105", 0, 2'b00, 0, 32'h105, 32'h0, 3, 32'h0000007F, 0, 1, 0, 32'h0);
    access("lb106", 0, 2'b00, 0, 32'h106, 32'h0, 3, 32'hFFFFFFF0, 0, 1, 0, 32'h0);

    // Halfword store RMW, upper lane
    access("sw108", 1, 2'b10, 0, 32'h108, 32'hCAFEF00D, 2, 32'h0, 0, 0, 1, 32'hCAFEF00D);
    access("sh10a", 1, 2'b01, 0, 32'h10A, 32'hFFFF5678, 4, 32'h0, 0, 1, 3, 32'h5678F00D);
    access("lhu10a", 0, 2'b01, 1, 32'h10A, 32'h0, 3, 32'h00005678, 0, 1, 0, 32'h0);
    access("lh108", 0, 2'b01, 0, 32'h108, 32'h0, 3, 32'hFFFFF00D, 0, 1, 0, 32'h0);

    // Misaligned / illegal
    access("lw101", 0, 2'b10, 0, 32'h101, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0);
    access("sh103", 1, 2'b01, 0, 32'h103, 32'h0000BEEF, 1, 32'h0, 1, 0, 0, 32'h0);
    access("sz11", 1, 2'b11, 0, 32'h100, 32'h12345678, 1, 32'h0, 1, 0, 0, 32'h0);
    access("lw100m", 0, 2'b10, 0, 32'h100, 32'h0, 3, 32'h11AB3344, 0, 1, 0, 32'h0);

    // Backpressure: second request queued behind the first
    a_resp = 0; b_acc = 0; b_resp = 0; overlap = 0; a_data = 32'h0; b_data = 32'h0;
    set_req(0, 2'b10, 0, 32'h100, 32'h0);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 set_req(0, 2'b10, 0, 32'h104, 32'h0);
    for (int c = 1; c <= 12 && b_resp == 0; c++) begin
      @(negedge clk);
      if (bus.resp_valid && bus.req_ready) overlap++;
      if (bus.resp_valid) begin
        if (a_resp == 0) begin
          a_resp = c;
          a_data = bus.resp_rdata;
        end else begin
          b_resp = c;
          b_data = bus.resp_rdata;
        end
      end
      go = bus.req_ready && bus.req_valid && (b_acc == 0);
      if (go) b_acc = c;
      @(posedge clk);
      #1 if (go) bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
    check_eq("bp/a_resp_cycle", a_resp, 3);
    check_eq("bp/b_accept_cycle", b_acc, 4);
    check_eq("bp/b_resp_cycle", b_resp, 7);
    check_eq("bp/a_data", a_data, 32'h11AB3344);
    check_eq("bp/b_data", b_data, 32'h80F07F01);
    check_eq("bp/overlap", overlap, 0);

    // Reset during WAIT of a byte store
    set_req(1, 2'b00, 0, 32'h101, 32'h00000055);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst           = 1'b1;
    bus.req_valid = 1'b1;
    set_req(1, 2'b10, 0, 32'h100, 32'hFFFFFFFF);
    @(negedge clk);
    check_eq("rmw_rst/ready", {31'h0, bus.req_ready}, 32'h0);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_outputs_zero("rmw_rst");
    activity = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.cs_en_riscv || bus.wr_en_riscv || bus.resp_valid) activity++;
    end
    check_eq("rmw_rst/activity", activity, 0);
    @(posedge clk);
    #1;
    access("lw100r", 0, 2'b10, 0, 32'h100, 32'h0, 3, 32'h11AB3344, 0, 1, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
